// File: rtl/tap_pkg.sv
// tap_pkg: shared definitions for the JTAG TAP controller.
//   - tap_state_t : 16 TAP states, standard 1149.1 4-bit encoding
//   - dr_sel_t    : which data register sits between tdi and tdo
//   - opcodes for the 4-bit reference instruction set, IR capture pattern
package tap_pkg;

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BSR,
        DR_IDCODE,
        DR_BYPASS
    } dr_sel_t;

    // Low opcodes are zero-extended to IR_WIDTH; BYPASS is always all-ones.
    localparam logic [3:0] OP_EXTEST = 4'b0000;
    localparam logic [3:0] OP_SAMPLE = 4'b0001;
    localparam logic [3:0] OP_IDCODE = 4'b0010;
    localparam logic [3:0] OP_BYPASS = 4'b1111;

    // Loaded into the IR shift register in Capture-IR (LSB first: 1,0,...).
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// tap_fsm: 16-state 1149.1 TAP state machine.
//   tck    in  test clock
//   trst_n in  async active-low reset (forces TLR)
//   tms    in  mode select, sampled on posedge tck
//   state  out current registered state
module tap_fsm
    import tap_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_t state
);

    tap_state_t nxt;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) state <= TLR;
        else         state <= nxt;
    end

    always_comb begin
        nxt = TLR;
        case (state)
            TLR:      nxt = tms ? TLR    : RTI;
            RTI:      nxt = tms ? SEL_DR : RTI;
            SEL_DR:   nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:   nxt = tms ? EX1_DR : SH_DR;
            SH_DR:    nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:   nxt = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: nxt = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   nxt = tms ? UPD_DR : SH_DR;
            UPD_DR:   nxt = tms ? SEL_DR : RTI;
            SEL_IR:   nxt = tms ? TLR    : CAP_IR;
            CAP_IR:   nxt = tms ? EX1_IR : SH_IR;
            SH_IR:    nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:   nxt = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: nxt = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   nxt = tms ? UPD_IR : SH_IR;
            UPD_IR:   nxt = tms ? SEL_DR : RTI;
            default:  nxt = TLR;
        endcase
    end

endmodule

// File: rtl/tap_controller.sv
// tap_controller: JTAG TAP with IR, bypass and IDCODE registers, instruction
// decode and boundary-scan control.
//   tck/trst_n          clock / async active-low reset
//   tms, tdi            JTAG inputs
//   tdo, tdo_en         serial out and its enable, both launched on negedge tck
//   bsr_so              serial out of the boundary chain
//   capture/shift/update_dr  boundary-cell controls, gated by EXTEST/SAMPLE
//   mode                boundary output-mux select (EXTEST)
//   ir_out, tap_state   current instruction and FSM state
module tap_controller
    import tap_pkg::*;
#(
    parameter int          IR_WIDTH = 4,
    parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic                bsr_so,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic                mode,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [3:0]          tap_state
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST = IR_WIDTH'(OP_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(OP_SAMPLE);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir, ir_sr;
    logic [31:0]         idcode_sr;
    logic                bypass;
    dr_sel_t             dr_sel;
    logic                dr_so;
    logic                bsr_sel;

    tap_fsm u_fsm (
        .tck    (tck),
        .trst_n (trst_n),
        .tms    (tms),
        .state  (state)
    );

    // Anything outside the defined opcodes falls back to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir == IR_EXTEST || ir == IR_SAMPLE) dr_sel = DR_BSR;
        else if (ir == IR_IDCODE)               dr_sel = DR_IDCODE;
    end

    always_comb begin
        dr_so = bypass;
        case (dr_sel)
            DR_BSR:    dr_so = bsr_so;
            DR_IDCODE: dr_so = idcode_sr[0];
            default:   dr_so = bypass;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir        <= IR_IDCODE;
            ir_sr     <= '0;
            bypass    <= 1'b0;
            idcode_sr <= '0;
        end else begin
            case (state)
                TLR:    ir    <= IR_IDCODE;
                CAP_IR: ir_sr <= IR_WIDTH'(IR_CAPTURE);
                SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
                UPD_IR: ir    <= ir_sr;
                CAP_DR: begin
                    if (dr_sel == DR_IDCODE) idcode_sr <= IDCODE;
                    if (dr_sel == DR_BYPASS) bypass    <= 1'b0;
                end
                SH_DR: begin
                    if (dr_sel == DR_IDCODE) idcode_sr <= {tdi, idcode_sr[31:1]};
                    if (dr_sel == DR_BYPASS) bypass    <= tdi;
                end
                default: ;  // pause/exit/select states hold everything
            endcase
        end
    end

    // Launch on the falling edge so the far end samples a settled tdo.
    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= (state == SH_DR) || (state == SH_IR);
            tdo    <= (state == SH_DR) ? dr_so :
                      (state == SH_IR) ? ir_sr[0] : 1'b0;
        end
    end

    // mode follows ir only, so it cannot move during a DR scan.
    assign bsr_sel    = (dr_sel == DR_BSR);
    assign capture_dr = bsr_sel && (state == CAP_DR);
    assign shift_dr   = bsr_sel && (state == SH_DR);
    assign update_dr  = bsr_sel && (state == UPD_DR);
    assign mode       = (ir == IR_EXTEST);
    assign ir_out     = ir;
    assign tap_state  = state;

endmodule
